// File: rtl/fq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fq_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fq_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Small synchronous FIFO of {pc, data} entries with flush and registered head outputs.
module fq_fifo
  import fq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = XLEN + ILEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop       = pop && (count_q != '0);
    do_push      = push && !flush && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_data_d  = head_data_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    head_valid_d = (count_d != '0);
    // An entry written this edge that lands at the new head must bypass the array.
    if (head_valid_d) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_data_d = push_data;
      else                                   head_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;
  assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, talks req/ack to imem, buffers for Decode.
// Optional performance counters are built when FQ_PERF_EN is defined.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst_data,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FQ_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fq_state_e       state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            req_q, req_d;
  logic            push, pop, flush;
  logic [AW:0]     fifo_count, occ_base;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN+ILEN-1:0] head_data;

  always_comb begin
    pop       = inst_valid & inst_ready;
    occ_base  = fifo_count - (AW+1)'(pop);
    redir_tgt = align_pc(redirect_pc);
    state_d   = state_q;
    addr_d    = addr_q;
    target_d  = target_q;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          flush   = 1'b1;
          addr_d  = redir_tgt;
          state_d = REQ;
        end else if (occ_base < FULL_CNT) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem_ack) begin
            addr_d = redir_tgt;
          end else begin
            // The memory still owns the old address; finish it and drop its data.
            target_d = redir_tgt;
            state_d  = DISCARD;
          end
        end else if (imem_ack) begin
          push   = 1'b1;
          addr_d = addr_q + PC_INC;
          if ((occ_base + (AW+1)'(1)) >= FULL_CNT) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (redirect) begin
          flush    = 1'b1;
          target_d = redir_tgt;
        end
        if (imem_ack) begin
          addr_d  = redirect ? redir_tgt : target_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      req_q    <= req_d;
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_data  ({addr_q, imem_rdata}),
    .head_valid (inst_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign inst_pc   = head_data[XLEN+ILEN-1:ILEN];
  assign inst_data = head_data[ILEN-1:0];

`ifdef FQ_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'b0, push};
    perf_flush_d = perf_flush_q + {31'b0, redirect};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
